// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - register map, status bit indices, FIFO depth and FSM states
package uart_apb_pkg;

  localparam logic [7:0] ADDR_CR     = 8'h00;
  localparam logic [7:0] ADDR_DVSR   = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_RXDATA = 8'h0C;
  localparam logic [7:0] ADDR_SR     = 8'h10;

  localparam int SR_TX_FULL    = 0;
  localparam int SR_TX_EMPTY   = 1;
  localparam int SR_RX_FULL    = 2;
  localparam int SR_RX_OVERRUN = 3;

  localparam int TX_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_STALL  = 2'd2
  } apb_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 4-entry byte FIFO feeding the UART transmitter
module uart_tx_fifo
  import uart_apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  logic [7:0] mem [TX_FIFO_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'(TX_FIFO_DEPTH));
  assign empty   = (count == 3'd0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a full FIFO may still accept.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_apb_slave.sv
// rtl/uart_apb_slave.sv - APB register slave for a UART with TX FIFO and single-byte RX holding register
// Define UART_APB_SLVERR_EN to report erroneous accesses on pslverr.
module uart_apb_slave
  import uart_apb_pkg::*;
(
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] dvsr,
  output logic        tx_en,
  output logic        rx_en
);

  apb_state_e  state;
  apb_state_e  state_nxt;
  logic [7:0]  addr;
  logic        hit_cr, hit_dvsr, hit_tx, hit_rx, hit_sr, mapped;
  logic        tx_full, tx_empty, tx_pop, tx_push;
  logic [2:0]  tx_count;
  logic        rx_full, rx_overrun, rx_pop;
  logic [7:0]  rx_byte;
  logic        in_access, stall, access_err;
  logic        commit, wr_commit, rd_commit, ovr_clr;
  logic [31:0] sr_val;
  logic [31:0] rd_mux;
  logic        unused_ok;

  assign addr     = paddr[7:0];
  assign hit_cr   = (addr == ADDR_CR);
  assign hit_dvsr = (addr == ADDR_DVSR);
  assign hit_tx   = (addr == ADDR_TXDATA);
  assign hit_rx   = (addr == ADDR_RXDATA);
  assign hit_sr   = (addr == ADDR_SR);
  assign mapped   = hit_cr | hit_dvsr | hit_tx | hit_rx | hit_sr;

  assign tx_valid  = (tx_count != 3'd0);
  assign tx_pop    = tx_valid & tx_ready;
  assign in_access = (state == ST_ACCESS) || (state == ST_STALL);
  assign stall     = pwrite & hit_tx & tx_full & ~tx_pop;
  assign pready    = in_access & ~stall;

`ifdef UART_APB_SLVERR_EN
  localparam logic [31:0] SR_W1C_MASK = 32'h1 << SR_RX_OVERRUN;
  assign access_err = ~mapped
                    | (pwrite & (hit_rx | (hit_sr & (|(pwdata & ~SR_W1C_MASK)))))
                    | (~pwrite & hit_tx);
`else
  assign access_err = 1'b0;
`endif
  assign pslverr = pready & access_err;

  // Flagged accesses complete on the bus but leave every register untouched.
  assign commit    = psel & penable & pready & ~access_err;
  assign wr_commit = commit & pwrite;
  assign rd_commit = commit & ~pwrite;
  assign tx_push   = wr_commit & hit_tx;
  assign rx_pop    = rd_commit & hit_rx & rx_full;
  assign ovr_clr   = wr_commit & hit_sr & pwdata[SR_RX_OVERRUN];

  assign unused_ok = &{1'b0, paddr[31:8], pwdata[31:16], mapped};

  always_comb begin
    sr_val                = 32'h0;
    sr_val[SR_TX_FULL]    = tx_full;
    sr_val[SR_TX_EMPTY]   = tx_empty;
    sr_val[SR_RX_FULL]    = rx_full;
    sr_val[SR_RX_OVERRUN] = rx_overrun;
  end

  always_comb begin
    rd_mux = 32'h0;
    if (!pwrite) begin
      case (addr)
        ADDR_CR:     rd_mux = {30'h0, rx_en, tx_en};
        ADDR_DVSR:   rd_mux = {16'h0, dvsr};
        ADDR_RXDATA: rd_mux = rx_full ? {24'h0, rx_byte} : 32'h0;
        ADDR_SR:     rd_mux = sr_val;
        default:     rd_mux = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (psel && !penable) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = pready ? ST_IDLE : ST_STALL;
      ST_STALL:  if (pready || !psel) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= ST_IDLE;
      prdata     <= 32'h0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      dvsr       <= 16'h0;
      rx_byte    <= 8'h0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && psel && !penable) begin
        prdata <= rd_mux;
      end
      if (wr_commit && hit_cr) begin
        {rx_en, tx_en} <= pwdata[1:0];
      end
      if (wr_commit && hit_dvsr) begin
        dvsr <= pwdata[15:0];
      end
      // A new byte arriving on a popping read replaces the byte being returned.
      if (rx_valid) begin
        rx_byte <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_pop) begin
        rx_full <= 1'b0;
      end
      if (rx_valid && rx_full && !rx_pop) begin
        rx_overrun <= 1'b1;
      end else if (ovr_clr) begin
        rx_overrun <= 1'b0;
      end
    end
  end

  uart_tx_fifo u_tx_fifo (
    .clk   (pclk),
    .rst   (preset),
    .push  (tx_push),
    .wdata (pwdata[7:0]),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

endmodule

// File: tb/tb_uart_apb_slave.sv
// tb/tb_uart_apb_slave.sv - directed self-checking bench for uart_apb_slave
module tb_uart_apb_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, tx_en, rx_en;
  logic [15:0] dvsr;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef UART_APB_SLVERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 pclk = ~pclk;

  uart_apb_slave dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .dvsr(dvsr),
    .tx_en(tx_en), .rx_en(rx_en)
  );

  // Called 1ns after a rising edge; returns 1ns after the completing edge.
  task automatic apb_xfer(input logic [31:0] addr, input logic [31:0] data, input logic wr,
                          output logic [31:0] rdata, output logic err, output logic rdy1);
    int waits;
    paddr = addr; pwdata = data; pwrite = wr; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    rdy1  = pready;
    rdata = prdata;
    waits = 0;
    while (!pready && waits < 20) begin
      @(posedge pclk); #1;
      waits++;
    end
    err = pslverr;
    n_cmp++; if (pready !== 1'b1) begin n_bad++; $display("FAIL apb_timeout addr=%h pready=%b exp=1", addr, pready); end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge pclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er, r1;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    n_cmp++; if (prdata !== 32'h0) begin n_bad++; $display("FAIL rst_prdata got=%h exp=0", prdata); end
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL rst_pready got=%b exp=0", pready); end
    n_cmp++; if (pslverr !== 1'b0) begin n_bad++; $display("FAIL rst_pslverr got=%b exp=0", pslverr); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h0) begin n_bad++; $display("FAIL rst_tx_data got=%h exp=0", tx_data); end
    n_cmp++; if ({tx_en, rx_en, dvsr} !== 18'h0) begin n_bad++; $display("FAIL rst_cfg got=%b%b %h exp=0", tx_en, rx_en, dvsr); end
    preset = 1'b0;
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rst_sr got=%h exp=2", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd; logic er, r1;
    apb_xfer(32'h00, 32'h3, 1'b1, rd, er, r1);
    n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL cr_wr_pready got=%b exp=1", r1); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL cr_wr_prdata got=%h exp=0", rd); end
    apb_xfer(32'h04, 32'h1B, 1'b1, rd, er, r1);
    n_cmp++; if ({tx_en, rx_en} !== 2'b11) begin n_bad++; $display("FAIL cr_en got=%b%b exp=11", tx_en, rx_en); end
    n_cmp++; if (dvsr !== 16'h001B) begin n_bad++; $display("FAIL dvsr got=%h exp=001b", dvsr); end
    apb_xfer(32'h00, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL cr_rd got=%h exp=3", rd); end
    n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL cr_rd_pready got=%b exp=1", r1); end
    apb_xfer(32'h04, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h1B) begin n_bad++; $display("FAIL dvsr_rd got=%h exp=1b", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er, r1;
    apb_xfer(32'h04, 32'h12345, 1'b1, rd, er, r1);
    apb_xfer(32'h04, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2345) begin n_bad++; $display("FAIL dvsr_trunc got=%h exp=2345", rd); end
    apb_xfer(32'h104, 32'hFFFF, 1'b1, rd, er, r1);
    n_cmp++; if (dvsr !== 16'hFFFF) begin n_bad++; $display("FAIL dvsr_alias got=%h exp=ffff", dvsr); end
    apb_xfer(32'h04, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'hFFFF) begin n_bad++; $display("FAIL dvsr_max_rd got=%h exp=ffff", rd); end
  endtask

  task automatic test_tx_fifo();
    logic [31:0] rd; logic er, r1;
    logic [7:0] exp_q [4];
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    tx_ready = 1'b0;
    apb_xfer(32'h08, 32'h11, 1'b1, rd, er, r1);
    apb_xfer(32'h08, 32'h22, 1'b1, rd, er, r1);
    apb_xfer(32'h08, 32'h33, 1'b1, rd, er, r1);
    apb_xfer(32'h08, 32'h44, 1'b1, rd, er, r1);
    n_cmp++; if ({tx_valid, tx_data} !== 9'h111) begin n_bad++; $display("FAIL tx_head got=%b %h exp=1 11", tx_valid, tx_data); end
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL sr_full got=%h exp=1", rd); end
    paddr = 32'h08; pwdata = 32'h55; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL stall_pready got=%b exp=0", pready); end
    @(posedge pclk); #1;
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL stall_hold got=%b exp=0", pready); end
    tx_ready = 1'b1;
    #1;
    n_cmp++; if (pready !== 1'b1) begin n_bad++; $display("FAIL stall_release got=%b exp=1", pready); end
    n_cmp++; if (tx_data !== 8'h11) begin n_bad++; $display("FAIL pop_head got=%h exp=11", tx_data); end
    @(posedge pclk); #1;
    tx_ready = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({tx_valid, tx_data} !== {1'b1, exp_q[i]}) begin n_bad++; $display("FAIL tx_order[%0d] got=%b %h exp=1 %h", i, tx_valid, tx_data, exp_q[i]); end
      tx_ready = 1'b1;
      @(posedge pclk); #1;
      tx_ready = 1'b0;
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL tx_drained got=%b exp=0", tx_valid); end
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL sr_empty got=%h exp=2", rd); end
  endtask

  task automatic test_rx_overrun();
    logic [31:0] rd; logic er, r1;
    rx_pulse(8'hA5);
    rx_pulse(8'h5A);
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'hE) begin n_bad++; $display("FAIL sr_overrun got=%h exp=e", rd); end
    apb_xfer(32'h0C, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h5A) begin n_bad++; $display("FAIL rx_latest got=%h exp=5a", rd); end
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'hA) begin n_bad++; $display("FAIL sr_after_pop got=%h exp=a", rd); end
    apb_xfer(32'h10, 32'h8, 1'b1, rd, er, r1);
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL sr_w1c got=%h exp=2", rd); end
    apb_xfer(32'h0C, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rx_empty_rd got=%h exp=0", rd); end
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL sr_after_empty_rd got=%h exp=2", rd); end
  endtask

  task automatic test_rx_coincident();
    logic [31:0] rd; logic er, r1;
    rx_pulse(8'hC3);
    paddr = 32'h0C; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1; rx_data = 8'h3C; rx_valid = 1'b1;
    n_cmp++; if (prdata !== 32'hC3) begin n_bad++; $display("FAIL coinc_prdata got=%h exp=c3", prdata); end
    n_cmp++; if (pready !== 1'b1) begin n_bad++; $display("FAIL coinc_pready got=%b exp=1", pready); end
    @(posedge pclk); #1;
    rx_valid = 1'b0; psel = 1'b0; penable = 1'b0;
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h6) begin n_bad++; $display("FAIL coinc_sr got=%h exp=6", rd); end
    apb_xfer(32'h0C, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h3C) begin n_bad++; $display("FAIL coinc_next got=%h exp=3c", rd); end
  endtask

  task automatic test_slverr();
    logic [31:0] rd; logic er, r1;
    apb_xfer(32'h20, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL unmapped_prdata got=%h exp=0", rd); end
    n_cmp++; if (er !== ERR_EXP) begin n_bad++; $display("FAIL unmapped_slverr got=%b exp=%b", er, ERR_EXP); end
    apb_xfer(32'h24, 32'h0, 1'b1, rd, er, r1);
    n_cmp++; if ({tx_en, rx_en} !== 2'b11) begin n_bad++; $display("FAIL unmapped_wr_cr got=%b%b exp=11", tx_en, rx_en); end
    apb_xfer(32'h08, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if ({rd, tx_valid} !== 33'h0) begin n_bad++; $display("FAIL txdata_rd got=%h %b exp=0 0", rd, tx_valid); end
    n_cmp++; if (er !== ERR_EXP) begin n_bad++; $display("FAIL txdata_rd_slverr got=%b exp=%b", er, ERR_EXP); end
    apb_xfer(32'h0C, 32'h77, 1'b1, rd, er, r1);
    n_cmp++; if (er !== ERR_EXP) begin n_bad++; $display("FAIL rxdata_wr_slverr got=%b exp=%b", er, ERR_EXP); end
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rxdata_wr_ignored got=%h exp=2", rd); end
  endtask

  task automatic test_reset_stall();
    logic [31:0] rd; logic er, r1;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) apb_xfer(32'h08, 32'hA0 + i, 1'b1, rd, er, r1);
    paddr = 32'h08; pwdata = 32'hA4; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL rs_stall got=%b exp=0", pready); end
    preset = 1'b1;
    @(posedge pclk); #1;
    n_cmp++; if (pready !== 1'b0) begin n_bad++; $display("FAIL rs_pready got=%b exp=0", pready); end
    n_cmp++; if ({tx_valid, tx_data} !== 9'h0) begin n_bad++; $display("FAIL rs_tx got=%b %h exp=0 00", tx_valid, tx_data); end
    n_cmp++; if ({tx_en, rx_en, dvsr} !== 18'h0) begin n_bad++; $display("FAIL rs_cfg got=%b%b %h exp=0", tx_en, rx_en, dvsr); end
    preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge pclk); #1;
    apb_xfer(32'h10, 32'h0, 1'b0, rd, er, r1);
    n_cmp++; if (rd !== 32'h2) begin n_bad++; $display("FAIL rs_sr got=%h exp=2", rd); end
    n_cmp++; if (r1 !== 1'b1) begin n_bad++; $display("FAIL rs_idle_access got=%b exp=1", r1); end
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
    test_reset();
    test_regs();
    test_back_to_back();
    test_tx_fifo();
    test_rx_overrun();
    test_rx_coincident();
    test_slverr();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_slave.md
UART_APB_SLAVE -- requirements
Module: uart_apb_slave

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: pclk is the single clock and preset is a synchronous active-high reset.
REQ-002 SHALL have ports:
- pclk  in  1  clock, all logic on rising edge.
- preset  in  1  synchronous active-high reset.
- paddr  in  32  APB address; only paddr[7:0] decoded.
- pwdata  in  32  APB write data.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts byte.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle received-byte strobe.
- dvsr  out  16  baud divider.
- tx_en  out  1  transmitter enable.
- rx_en  out  1  receiver enable.

Function
REQ-003 SHALL implement the register map: 0x00 CR (bit0 tx_en, bit1 rx_en, RW); 0x04 DVSR ([15:0], RW); 0x08 TXDATA (WO, push [7:0]); 0x0C RXDATA (RO, pop); 0x10 SR (bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_overrun W1C).
REQ-004 SHALL run a slave FSM with states IDLE, ACCESS, STALL: IDLE->ACCESS on psel&!penable; ACCESS->IDLE when pready=1; ACCESS->STALL on TXDATA write with FIFO full; STALL->IDLE when FIFO gains space and the write completes.
REQ-005 SHALL register prdata at the end of the setup cycle so it is valid in the first access cycle; prdata SHALL read 0 for write transfers and unmapped addresses.
REQ-006 SHALL assert pready combinationally in ACCESS and STALL, except a TXDATA write with FIFO full holds pready=0 until a slot frees.
REQ-007 SHALL commit register writes, FIFO push and RX pop only in the cycle psel&penable&pready=1.
REQ-008 SHALL contain a 4-entry TX FIFO: 2-bit pointers wrap 3->0; a 3-bit count covers 0..4; tx_valid = !empty; tx_data = head entry; pop on tx_valid&tx_ready.
REQ-009 SHALL, on simultaneous push and pop with FIFO full, retire the pop and accept the push in the same cycle (stall released), with count unchanged.
REQ-010 SHALL hold one RX byte: rx_valid loads rx_data and sets rx_full; rx_valid while rx_full and no pop in that cycle sets rx_overrun, and the old byte is overwritten.
REQ-011 SHALL, on an RXDATA read coincident with rx_valid, return the old byte and load the new one, keeping rx_full=1 with no overrun.
REQ-012 SHALL return 0x00 for an RXDATA read with rx_full=0, with no state change.
REQ-013 SHALL ignore writes to RO registers and reads of WO registers (read 0).

Reset
REQ-014 SHALL, with preset=1 at a pclk edge, drive: prdata=0, pready=0, pslverr=0, tx_valid=0, tx_data=0, dvsr=0, tx_en=0, rx_en=0, FIFO empty, rx_full=0, rx_overrun=0, FSM=IDLE.
REQ-015 SHALL, on reset during a transfer (including STALL), abort the transfer and commit nothing.

Configuration
REQ-016 SHALL, with UART_APB_SLVERR_EN defined, assert pslverr with pready for unmapped addresses, writes to RXDATA/SR bits other than bit3, and reads of TXDATA; the erroneous access SHALL have no side effect.
REQ-017 SHALL, without UART_APB_SLVERR_EN, tie pslverr to 0; REQ-013 behaviour is otherwise unchanged.

Structure
REQ-018 SHALL place the register offsets, SR bit indices, FIFO depth (4) and the FSM state enum in package uart_apb_pkg.
REQ-019 SHALL implement the TX FIFO as sub-module uart_tx_fifo (push, pop, full, empty, count).

Verification
REQ-020 Write 0x00000003 to 0x00, 0x0000001B to 0x04 -> tx_en=1, rx_en=1, dvsr=0x001B; read back equal; pready high in first access cycle.
REQ-021 With tx_ready=0, write 0x11,0x22,0x33,0x44 to 0x08 -> SR=0x1 (tx_full); fifth write 0x55 stalls (pready=0); pulse tx_ready -> tx_data 0x11 popped, write completes in that cycle, FIFO order 0x22,0x33,0x44,0x55.
REQ-022 Pulse rx_valid with 0xA5, then 0x5A, no read -> SR bit3=1, RXDATA reads 0x5A; write 0x8 to SR -> bit3=0.
REQ-023 RXDATA read access cycle coincident with rx_valid 0x3C while holding 0xC3 -> prdata=0xC3, rx_full stays 1, overrun 0, next read 0x3C.
REQ-024 Read 0x20 with UART_APB_SLVERR_EN -> pslverr=1, prdata=0; without the macro -> pslverr=0.
REQ-025 Assert preset during STALL -> next cycle pready=0, FIFO empty, tx_valid=0, FSM IDLE.
